dcache_responder: RTL and testbench

Direct-mapped, write-back, write-allocate data cache. It is the responder on the pipeline's D-cache interface: it answers `dcache_read`/`dcache_write` requests from the MEM stage with `dcache_resp`/`dcache_rdata`. On the lower side it is the initiator of 256-bit cacheline transfers to physical memory. Hits complete in the request cycle, so the pipeline stalls only on misses.

---
 rtl/dcache_responder.sv | 153 +++++++++++++++
 tb/tb_dcache_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate D-cache responder with 256-bit line refill/eviction.
// Optional hit/miss performance counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_responder #(
    parameter int unsigned S_INDEX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   mem_address,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_byte_enable,
    output logic          mem_resp,
    output logic [31:0]   mem_rdata,
    output logic [31:0]   pmem_address,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [255:0]  pmem_wdata,
    input  logic [255:0]  pmem_rdata,
    input  logic          pmem_resp,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
);
    localparam int unsigned SETS  = 2 ** S_INDEX;
    localparam int unsigned TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t             r_state;
    logic               r_valid [SETS];
    logic               r_dirty [SETS];
    logic [TAG_W-1:0]   r_tag   [SETS];
    logic [255:0]       r_data  [SETS];
    logic               r_pmem_read;
    logic               r_pmem_write;
    logic [31:0]        r_pmem_address;
    logic [255:0]       r_pmem_wdata;

    logic [S_INDEX-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [2:0]         w_word;
    logic [255:0]       w_line;
    logic               w_req;
    logic               w_hit;
    logic               w_resp;
    logic               w_miss;

    assign w_idx  = mem_address[5+S_INDEX-1:5];
    assign w_tag  = mem_address[31:5+S_INDEX];
    assign w_word = mem_address[4:2];
    assign w_line = r_data[w_idx];
    assign w_req  = mem_read | mem_write;
    assign w_hit  = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_resp = (r_state == IDLE) & w_hit;
    assign w_miss = (r_state == IDLE) & w_req & ~w_hit;

    assign mem_resp     = w_resp;
    assign mem_rdata    = w_resp ? w_line[{w_word, 5'b00000} +: 32] : '0;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= 1'b0;
                r_dirty[s] <= 1'b0;
                r_tag[s]   <= '0;
                r_data[s]  <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    // A simultaneous read+write is serviced as a write.
                    if (w_resp && mem_write) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (mem_byte_enable[i])
                                r_data[w_idx][{w_word, i[1:0], 3'b000} +: 8] <= mem_wdata[8*i +: 8];
                        end
                        r_dirty[w_idx] <= 1'b1;
                    end else if (w_miss) begin
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state        <= WRITEBACK;
                            r_pmem_write   <= 1'b1;
                            r_pmem_address <= {r_tag[w_idx], w_idx, 5'b00000};
                            r_pmem_wdata   <= w_line;
                        end else begin
                            r_state        <= FILL;
                            r_pmem_read    <= 1'b1;
                            r_pmem_address <= {mem_address[31:5], 5'b00000};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= FILL;
                        r_pmem_write   <= 1'b0;
                        r_pmem_read    <= 1'b1;
                        r_pmem_address <= {mem_address[31:5], 5'b00000};
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        r_data[w_idx]  <= pmem_rdata;
                        r_tag[w_idx]   <= w_tag;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_pmem_read    <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic        r_refill;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // r_refill marks the IDLE cycle right after a fill, where the held request completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refill   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_refill <= (r_state == FILL) && pmem_resp;
            if (w_resp && !r_refill && (r_hit_cnt != '1))
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

    a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: cold miss, write merge, dirty eviction,
// back-to-back hits, reset during fill and the optional performance counters.
module tb_dcache_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int passes = 0;
    int total  = 0;

    logic [255:0] line1, line2, line3;

    dcache_responder #(.S_INDEX(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            line1[32*k +: 32] = 32'hA0A0_0000 + 32'(k);
            line2[32*k +: 32] = 32'hB0B0_0000 + 32'(k);
            line3[32*k +: 32] = 32'hC0C0_0000 + 32'(k);
        end
        line1[63:32] = 32'hDEAD_BEEF;

        rst = 1'b1; mem_address = '0; mem_read = 0; mem_write = 0; mem_wdata = '0;
        mem_byte_enable = '0; pmem_rdata = '0; pmem_resp = 0;
        cyc(); cyc(); #1;
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        cyc(); rst = 1'b0;

        // Stray pmem_resp while idle must be ignored
        cyc(); pmem_resp = 1; pmem_rdata = line3;
        cyc(); pmem_resp = 0; #1;
        chk("idle_resp_pmem_read", pmem_read, 0);

        // Cold read miss
        cyc(); mem_read = 1; mem_address = 32'h0000_0104; #1;
        chk("cold_no_resp", mem_resp, 0);
        cyc(); #1;
        chk("cold_pmem_read", pmem_read, 1);
        chk("cold_pmem_addr", pmem_address, 32'h0000_0100);
        chk("cold_no_pmem_write", pmem_write, 0);
        chk("cold_wait_resp", mem_resp, 0);
        cyc();
        cyc(); pmem_resp = 1; pmem_rdata = line1; #1;
        chk("cold_pmem_read_held", pmem_read, 1);
        cyc(); pmem_resp = 0; #1;
        chk("cold_mem_resp", mem_resp, 1);
        chk("cold_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("cold_pmem_read_drop", pmem_read, 0);
        chk("cold_no_pmem_write2", pmem_write, 0);

        // Write hit with byte merge, then read back
        cyc(); mem_read = 0; mem_write = 1; mem_wdata = 32'h0000_AB00; mem_byte_enable = 4'b0010; #1;
        chk("wr_hit_resp", mem_resp, 1);
        cyc(); mem_write = 0; mem_read = 1; mem_byte_enable = '0; #1;
        chk("rd_hit_resp", mem_resp, 1);
        chk("rd_merged", mem_rdata, 32'hDEAD_ABEF);

        // Dirty eviction on conflicting tag
        cyc(); mem_address = 32'h0000_1104; #1;
        chk("evict_no_resp", mem_resp, 0);
        cyc(); #1;
        chk("wb_pmem_write", pmem_write, 1);
        chk("wb_pmem_read_low", pmem_read, 0);
        chk("wb_pmem_addr", pmem_address, 32'h0000_0100);
        chk("wb_word1", pmem_wdata[63:32], 32'hDEAD_ABEF);
        chk("wb_word0", pmem_wdata[31:0], 32'hA0A0_0000);
        chk("wb_no_resp", mem_resp, 0);
        cyc(); pmem_resp = 1; #1;
        chk("wb_pmem_write_held", pmem_write, 1);
        cyc(); pmem_resp = 0; #1;
        chk("fill2_pmem_write_drop", pmem_write, 0);
        chk("fill2_pmem_read", pmem_read, 1);
        chk("fill2_pmem_addr", pmem_address, 32'h0000_1100);
        pmem_resp = 1; pmem_rdata = line2;
        cyc(); pmem_resp = 0; #1;
        chk("fill2_mem_resp", mem_resp, 1);
        chk("fill2_mem_rdata", mem_rdata, 32'hB0B0_0001);

        // Back-to-back hits (continuing from the miss completion above)
        cyc(); mem_address = 32'h0000_1108; #1;
        chk("b2b_resp_w2", mem_resp, 1);
        chk("b2b_data_w2", mem_rdata, 32'hB0B0_0002);
        cyc(); mem_address = 32'h0000_110C; #1;
        chk("b2b_resp_w3", mem_resp, 1);
        chk("b2b_data_w3", mem_rdata, 32'hB0B0_0003);
        cyc(); mem_address = 32'h0000_1100; #1;
        chk("b2b_resp_w0", mem_resp, 1);
        chk("b2b_data_w0", mem_rdata, 32'hB0B0_0000);
        cyc(); mem_read = 0; #1;
        chk("idle_no_resp", mem_resp, 0);
`ifdef DCACHE_PERF_CNT_EN
        chk("cnt_miss", miss_count, 2);
        chk("cnt_hit", hit_count, 5);
`else
        chk("cnt_miss_off", miss_count, 0);
        chk("cnt_hit_off", hit_count, 0);
`endif

        // Reset during fill
        cyc(); mem_read = 1; mem_address = 32'h0000_2104;
        cyc(); #1;
        chk("rf_pmem_read", pmem_read, 1);
        chk("rf_pmem_addr", pmem_address, 32'h0000_2100);
        #1 rst = 1'b1; #1;
        chk("rf_async_drop", pmem_read, 0);
        chk("rf_cnt_clear", miss_count, 0);
        mem_read = 0;
        cyc(); rst = 1'b0;
        cyc(); pmem_resp = 1; pmem_rdata = line3;
        cyc(); pmem_resp = 0; mem_read = 1; #1;
        chk("rf_remiss", mem_resp, 0);
        cyc(); #1;
        chk("rf_refill_read", pmem_read, 1);
        chk("rf_refill_addr", pmem_address, 32'h0000_2100);
        pmem_resp = 1; pmem_rdata = line3;
        cyc(); pmem_resp = 0; #1;
        chk("rf_done_resp", mem_resp, 1);
        chk("rf_done_data", mem_rdata, 32'hC0C0_0001);
        cyc(); mem_read = 0; #1;
`ifdef DCACHE_PERF_CNT_EN
        chk("rf_cnt_miss", miss_count, 1);
        chk("rf_cnt_hit", hit_count, 0);
`else
        chk("rf_cnt_miss_off", miss_count, 0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
